// File: rtl/datapath_bus.sv
// datapath_bus: register file (PC, AR, IR, AC, R, R1-R4), shared bus mux,
// ALU, zero flag and the instruction/data memory ports. Responds to the
// controller's read/write/inc/clr strobes.
// Optional build macro DP_HALT_FREEZE_EN adds a 'halt' input that freezes
// all state updates and blocks DM writes (reset still wins).
module datapath_bus #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DP_HALT_FREEZE_EN
  input  logic              halt,
`endif
  input  logic [3:0]        read_en,
  input  logic [15:0]       write_en,
  input  logic [15:0]       inc_en,
  input  logic [15:0]       clr_en,
  input  logic [2:0]        alu_op,
  output logic [OPC_W-1:0]  instruction,
  output logic [15:0]       z,
  output logic [DATA_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_rdata,
  output logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic              bus_err
);

  localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] pc, ar, ir, ac, r, r1, r2, r3, r4;
  logic              zf;
  logic [DATA_W-1:0] bus;
  logic              illegal;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] pc_next, ar_next, ac_next;
  logic              ac_upd;
  logic              freeze;
  logic              unused_bits;

`ifdef DP_HALT_FREEZE_EN
  assign freeze = halt;
`else
  assign freeze = 1'b0;
`endif

  // Strobe bits with no register behind them are deliberately ignored.
  assign unused_bits = ^{write_en[15:13], write_en[6], write_en[0],
                         inc_en[15:5], inc_en[3:2], inc_en[0],
                         clr_en[15:5], clr_en[3], clr_en[0]};

  assign instruction = ir[OPC_W-1:0];
  assign z           = {15'd0, zf};
  assign im_addr     = pc;
  assign dm_addr     = ar;
  assign dm_wdata    = bus;
  assign dm_we       = write_en[11] & ~freeze;

  // Shared bus source select; unassigned codes drive zero and flag an error.
  always_comb begin
    bus     = ZERO;
    illegal = 1'b0;
    case (read_en)
      4'd0:    bus = ZERO;
      4'd1:    bus = pc;
      4'd2:    bus = ar;
      4'd4:    bus = ir >> OPC_W;
      4'd5:    bus = ac;
      4'd6:    bus = r;
      4'd7:    bus = r1;
      4'd8:    bus = r2;
      4'd9:    bus = r3;
      4'd10:   bus = r4;
      4'd12:   bus = dm_rdata;
      4'd13:   bus = im_rdata;
      default: begin
        bus     = ZERO;
        illegal = 1'b1;
      end
    endcase
  end

  // ALU on AC and R, result truncated to the datapath width.
  always_comb begin
    alu_res = ac;
    case (alu_op)
      3'd1:    alu_res = ac + r;
      3'd2:    alu_res = ac - r;
      3'd3:    alu_res = ac * r;
      3'd4:    alu_res = {ac[DATA_W-2:0], 1'b0};
      default: alu_res = ac;
    endcase
  end

  // PC next value: clear beats load beats increment.
  always_comb begin
    pc_next = pc;
    if (clr_en[1]) begin
      pc_next = ZERO;
    end else if (write_en[1]) begin
      pc_next = bus;
    end else if (inc_en[1]) begin
      pc_next = pc + ONE;
    end else begin
      pc_next = pc;
    end
  end

  // AR next value: clear beats load.
  always_comb begin
    ar_next = ar;
    if (clr_en[2]) begin
      ar_next = ZERO;
    end else if (write_en[2]) begin
      ar_next = bus;
    end else begin
      ar_next = ar;
    end
  end

  // AC next value: clear > ALU load > bus load > increment; ac_upd marks a change.
  always_comb begin
    ac_next = ac;
    ac_upd  = 1'b1;
    if (clr_en[4]) begin
      ac_next = ZERO;
    end else if (write_en[12]) begin
      ac_next = alu_res;
    end else if (write_en[4]) begin
      ac_next = bus;
    end else if (inc_en[4]) begin
      ac_next = ac + ONE;
    end else begin
      ac_next = ac;
      ac_upd  = 1'b0;
    end
  end

  // Register file, zero flag and sticky bus error; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= ZERO;
      ar      <= ZERO;
      ir      <= ZERO;
      ac      <= ZERO;
      r       <= ZERO;
      r1      <= ZERO;
      r2      <= ZERO;
      r3      <= ZERO;
      r4      <= ZERO;
      zf      <= 1'b0;
      bus_err <= 1'b0;
    end else if (!freeze) begin
      pc <= pc_next;
      ar <= ar_next;
      ac <= ac_next;
      if (write_en[3])  ir <= bus;
      if (write_en[5])  r  <= bus;
      if (write_en[10]) r1 <= bus;
      if (write_en[9])  r2 <= bus;
      if (write_en[8])  r3 <= bus;
      if (write_en[7])  r4 <= bus;
      if (ac_upd)       zf <= (ac_next == ZERO);
      if (illegal)      bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_datapath_bus.sv
// Self-checking bench for datapath_bus: a directed vector table, hand-written
// multi-cycle sequences, then randomized cycles against a reference model.
module tb_datapath_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt_v = 1'b0;
  logic [3:0]  read_en = 4'd0;
  logic [15:0] write_en = 16'd0, inc_en = 16'd0, clr_en = 16'd0;
  logic [2:0]  alu_op = 3'd0;
  logic [5:0]  instruction;
  logic [15:0] z, im_addr, im_rdata = 16'd0, dm_addr, dm_rdata = 16'd0, dm_wdata;
  logic        dm_we, bus_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  datapath_bus dut (
    .clk(clk), .rst(rst),
`ifdef DP_HALT_FREEZE_EN
    .halt(halt_v),
`endif
    .read_en(read_en), .write_en(write_en), .inc_en(inc_en), .clr_en(clr_en),
    .alu_op(alu_op), .instruction(instruction), .z(z),
    .im_addr(im_addr), .im_rdata(im_rdata), .dm_addr(dm_addr),
    .dm_rdata(dm_rdata), .dm_wdata(dm_wdata), .dm_we(dm_we), .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mr[n] is the register loaded by write_en[n] (1 PC, 2 AR, 3 IR, 4 AC, 5 R, 7 R4 .. 10 R1).
  logic [15:0] mr [16];
  logic        mz = 1'b0, merr = 1'b0;
  int          wl [9] = '{1, 2, 3, 4, 5, 7, 8, 9, 10};

  function automatic logic [15:0] m_bus(input logic [3:0] rd, input logic [15:0] im, input logic [15:0] dm);
    int k;
    k = int'(rd);
    if (k == 1 || k == 2) return mr[k];
    if (k == 4) return mr[3] / 16'd64;
    if (k == 5 || k == 6) return mr[k - 1];
    if (k >= 7 && k <= 10) return mr[17 - k];
    if (k == 12) return dm;
    if (k == 13) return im;
    return 16'd0;
  endfunction

  function automatic logic [15:0] m_alu(input logic [2:0] op);
    logic [31:0] p;
    case (op)
      3'd1: p = mr[4] + mr[5];
      3'd2: p = {16'd0, mr[4]} + 32'h10000 - {16'd0, mr[5]};
      3'd3: p = {16'd0, mr[4]} * {16'd0, mr[5]};
      3'd4: p = {16'd0, mr[4]} * 32'd2;
      default: p = {16'd0, mr[4]};
    endcase
    return p[15:0];
  endfunction

  task automatic m_step(input logic r, input logic [3:0] rd, input logic [15:0] we, input logic [15:0] inc,
                        input logic [15:0] clr, input logic [2:0] op, input logic [15:0] im,
                        input logic [15:0] dm, input logic h);
    logic [15:0] nv [16];
    logic [15:0] b, a;
    if (r) begin
      for (int i = 0; i < 16; i++) mr[i] = 16'd0;
      mz = 1'b0;
      merr = 1'b0;
    end else if (!h) begin
      b = m_bus(rd, im, dm);
      a = m_alu(op);
      nv = mr;
      if (inc[1]) nv[1] = mr[1] + 16'd1;
      if (inc[4]) nv[4] = mr[4] + 16'd1;
      for (int i = 0; i < 9; i++) if (we[wl[i]]) nv[wl[i]] = b;
      if (we[12]) nv[4] = a;
      if (clr[1]) nv[1] = 16'd0;
      if (clr[2]) nv[2] = 16'd0;
      if (clr[4]) nv[4] = 16'd0;
      if (inc[4] || we[4] || we[12] || clr[4]) mz = (nv[4] == 16'd0);
      if (rd == 4'd3 || rd == 4'd11 || rd >= 4'd14) merr = 1'b1;
      mr = nv;
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rd, input logic [15:0] we, input logic [15:0] inc,
                       input logic [15:0] clr, input logic [2:0] op, input logic [15:0] im, input logic [15:0] dm);
    rst = r; read_en = rd; write_en = we; inc_en = inc; clr_en = clr;
    alu_op = op; im_rdata = im; dm_rdata = dm;
  endtask

  // One cycle compared against the model: starts and ends on a negedge.
  task automatic step(input logic r, input logic [3:0] rd, input logic [15:0] we, input logic [15:0] inc,
                      input logic [15:0] clr, input logic [2:0] op, input logic [15:0] im, input logic [15:0] dm);
    drive(r, rd, we, inc, clr, op, im, dm);
    #1;
    chk("m_dm_wdata", {16'd0, dm_wdata}, {16'd0, m_bus(rd, im, dm)});
    chk("m_dm_we", {31'd0, dm_we}, {31'd0, we[11] & ~halt_v});
    @(posedge clk);
    m_step(r, rd, we, inc, clr, op, im, dm, halt_v);
    #1;
    chk("m_im_addr", {16'd0, im_addr}, {16'd0, mr[1]});
    chk("m_dm_addr", {16'd0, dm_addr}, {16'd0, mr[2]});
    chk("m_instruction", {26'd0, instruction}, {26'd0, mr[3][5:0]});
    chk("m_z", {16'd0, z}, {16'd0, 15'd0, mz});
    chk("m_bus_err", {31'd0, bus_err}, {31'd0, merr});
    @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic rst; logic [3:0] rd; logic [15:0] we, inc, clr; logic [2:0] op; logic [15:0] im, dm;
    logic [15:0] x_wdata; logic x_we; logic [15:0] x_pc, x_ar; logic [5:0] x_ins; logic x_z, x_err;
  } vec_t;

  localparam logic [15:0] B1 = 16'h0002, B2 = 16'h0004, B3 = 16'h0008, B4 = 16'h0010, B5 = 16'h0020;
  localparam logic [15:0] B7 = 16'h0080, B9 = 16'h0200, B10 = 16'h0400, B11 = 16'h0800, B12 = 16'h1000;
  localparam logic [15:0] N0 = 16'h0000;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] rd, logic [15:0] we, logic [15:0] inc, logic [15:0] clr,
                              logic [2:0] op, logic [15:0] im, logic [15:0] dm, logic [15:0] xw, logic xwe,
                              logic [15:0] xpc, logic [15:0] xar, logic [5:0] xins, logic xz, logic xerr);
    vec_t v;
    v.rst = r; v.rd = rd; v.we = we; v.inc = inc; v.clr = clr; v.op = op; v.im = im; v.dm = dm;
    v.x_wdata = xw; v.x_we = xwe; v.x_pc = xpc; v.x_ar = xar; v.x_ins = xins; v.x_z = xz; v.x_err = xerr;
    return v;
  endfunction

  initial begin
    vec_t v;
    for (int i = 0; i < 16; i++) mr[i] = 16'd0;
    //                rst rd     we        inc      clr  op    im        dm        wdata    we  pc        ar        ins    z     err
    tbl.push_back(mk(1'b1, 4'd12, B4,      N0,      N0,  3'd0, N0,       16'h00FF, 16'h00FF,1'b0,N0,      N0,       6'h00,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd5,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h0000,1'b0,N0,      N0,       6'h00,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd13, B3,      N0,      N0,  3'd0, 16'h0283, N0,       16'h0283,1'b0,N0,      N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd0,  N0,      B1,      N0,  3'd0, N0,       N0,       16'h0000,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd4,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h000A,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B4|B5,   N0,      N0,  3'd0, N0,       16'h0005, 16'h0005,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd0,  B12,     N0,      N0,  3'd2, N0,       N0,       16'h0000,1'b0,16'h0001,N0,       6'h03,1'b1,1'b0));
    tbl.push_back(mk(1'b0, 4'd5,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h0000,1'b0,16'h0001,N0,       6'h03,1'b1,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B4,      N0,      N0,  3'd0, N0,       16'h0003, 16'h0003,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B5,      N0,      N0,  3'd0, N0,       16'h8001, 16'h8001,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd0,  B12,     N0,      N0,  3'd3, N0,       N0,       16'h0000,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd5,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h8003,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd0,  B12,     N0,      N0,  3'd4, N0,       N0,       16'h0000,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd5,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h0006,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd0,  B12,     N0,      N0,  3'd1, N0,       N0,       16'h0000,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd5,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h8007,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd0,  B12,     N0,      N0,  3'd7, N0,       N0,       16'h0000,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd5,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h8007,1'b0,16'h0001,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B1,      N0,      N0,  3'd0, N0,       16'hFFFF, 16'hFFFF,1'b0,16'hFFFF,N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B4,      B1|B4,   B4,  3'd0, N0,       16'h1234, 16'h1234,1'b0,N0,      N0,       6'h03,1'b1,1'b0));
    tbl.push_back(mk(1'b0, 4'd5,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h0000,1'b0,N0,      N0,       6'h03,1'b1,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B1,      B1,      N0,  3'd0, N0,       16'h0040, 16'h0040,1'b0,16'h0040,N0,       6'h03,1'b1,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B1,      B1,      B1,  3'd0, N0,       16'h0050, 16'h0050,1'b0,N0,      N0,       6'h03,1'b1,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B4|B12,  N0,      N0,  3'd1, N0,       16'h7777, 16'h7777,1'b0,N0,      N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd5,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h8001,1'b0,N0,      N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd0,  N0,      B4,      N0,  3'd0, N0,       N0,       16'h0000,1'b0,N0,      N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd5,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h8002,1'b0,N0,      N0,       6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B2,      N0,      N0,  3'd0, N0,       16'h0010, 16'h0010,1'b0,N0,      16'h0010, 6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B4,      N0,      N0,  3'd0, N0,       16'h1234, 16'h1234,1'b0,N0,      16'h0010, 6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd5,  B11,     N0,      N0,  3'd0, N0,       N0,       16'h1234,1'b1,N0,      16'h0010, 6'h03,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd14, N0,      N0,      N0,  3'd0, N0,       N0,       16'h0000,1'b0,N0,      16'h0010, 6'h03,1'b0,1'b1));
    tbl.push_back(mk(1'b0, 4'd5,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h1234,1'b0,N0,      16'h0010, 6'h03,1'b0,1'b1));
    tbl.push_back(mk(1'b1, 4'd5,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h1234,1'b0,N0,      N0,       6'h00,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B10,     N0,      N0,  3'd0, N0,       16'h1111, 16'h1111,1'b0,N0,      N0,       6'h00,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd7,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h1111,1'b0,N0,      N0,       6'h00,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, B7|B9,   N0,      N0,  3'd0, N0,       16'h2222, 16'h2222,1'b0,N0,      N0,       6'h00,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd10, N0,      N0,      N0,  3'd0, N0,       N0,       16'h2222,1'b0,N0,      N0,       6'h00,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd8,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h2222,1'b0,N0,      N0,       6'h00,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd9,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h0000,1'b0,N0,      N0,       6'h00,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd12, 16'hE041,N0,      N0,  3'd0, N0,       16'hABCD, 16'hABCD,1'b0,N0,      N0,       6'h00,1'b0,1'b0));
    tbl.push_back(mk(1'b0, 4'd3,  N0,      N0,      N0,  3'd0, N0,       N0,       16'h0000,1'b0,N0,      N0,       6'h00,1'b0,1'b1));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.rst, v.rd, v.we, v.inc, v.clr, v.op, v.im, v.dm);
      #1;
      chk($sformatf("row%0d_dm_wdata", i), {16'd0, dm_wdata}, {16'd0, v.x_wdata});
      chk($sformatf("row%0d_dm_we", i), {31'd0, dm_we}, {31'd0, v.x_we});
      @(posedge clk);
      m_step(v.rst, v.rd, v.we, v.inc, v.clr, v.op, v.im, v.dm, halt_v);
      #1;
      chk($sformatf("row%0d_pc", i), {16'd0, im_addr}, {16'd0, v.x_pc});
      chk($sformatf("row%0d_ar", i), {16'd0, dm_addr}, {16'd0, v.x_ar});
      chk($sformatf("row%0d_instruction", i), {26'd0, instruction}, {26'd0, v.x_ins});
      chk($sformatf("row%0d_z", i), {16'd0, z}, {31'd0, v.x_z});
      chk($sformatf("row%0d_bus_err", i), {31'd0, bus_err}, {31'd0, v.x_err});
      @(negedge clk);
    end

    // bus_err stays set across idle cycles and only reset clears it.
    step(1'b0, 4'd11, N0, N0, N0, 3'd0, N0, N0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd0, N0, N0, N0, 3'd0, N0, N0);
      chk($sformatf("err_hold%0d", i), {31'd0, bus_err}, 32'd1);
    end
    step(1'b1, 4'd0, N0, N0, N0, 3'd0, N0, N0);
    chk("err_cleared", {31'd0, bus_err}, 32'd0);

`ifdef DP_HALT_FREEZE_EN
    // Halted cycle: the AC load and the DM write are both blocked.
    step(1'b0, 4'd12, B4, N0, N0, 3'd0, N0, 16'h0100);
    halt_v = 1'b1;
    drive(1'b0, 4'd12, B4 | B11 | B1, B1, N0, 3'd0, N0, 16'h0042);
    #1;
    chk("halt_dm_we", {31'd0, dm_we}, 32'd0);
    @(posedge clk);
    m_step(1'b0, 4'd12, B4 | B11 | B1, B1, N0, 3'd0, N0, 16'h0042, 1'b1);
    #1;
    chk("halt_pc", {16'd0, im_addr}, 32'd0);
    @(negedge clk);
    halt_v = 1'b0;
    drive(1'b0, 4'd5, N0, N0, N0, 3'd0, N0, N0);
    #1;
    chk("halt_ac_kept", {16'd0, dm_wdata}, 32'h0100);
    @(posedge clk);
    @(negedge clk);
    step(1'b0, 4'd12, B4, N0, N0, 3'd0, N0, 16'h0042);
    drive(1'b0, 4'd5, N0, N0, N0, 3'd0, N0, N0);
    #1;
    chk("unhalt_ac_loaded", {16'd0, dm_wdata}, 32'h0042);
    @(posedge clk);
    @(negedge clk);
`endif

    // Randomized cycles against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] rwe, rinc, rclr;
      rwe  = 16'($urandom & $urandom & $urandom);
      rinc = 16'($urandom & $urandom);
      rclr = 16'($urandom & $urandom & $urandom);
      step(($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)), rwe, rinc, rclr,
           3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_bus.md
Name: datapath_bus

Overview:
- Responder side of the control-unit strobe interface.
- Holds the processor registers: PC, AR, IR, AC, R, R1-R4.
- Contains the shared bus multiplexer and the ALU, and drives the external instruction-memory (IM) and data-memory (DM) ports.
- Consumes `read_en` / `write_en` / `inc_en` / `clr_en` / `alu_op` from the controller and returns `instruction` and `z`.

Parameters:
- DATA_W, 16: width of bus, registers, memory data and addresses.
- OPC_W, 6: opcode field width; opcode is IR[OPC_W-1:0].

Ports:
- clk  in  1  system clock; all registers update on posedge.
- rst  in  1  synchronous active-high reset.
- read_en  in  4  bus source select code.
- write_en  in  16  register load strobes.
- inc_en  in  16  register increment strobes.
- clr_en  in  16  register clear strobes.
- alu_op  in  3  ALU operation.
- instruction  out  OPC_W  IR[OPC_W-1:0].
- z  out  16  16'd1 when the zero flag is set, else 16'd0.
- im_addr  out  DATA_W  equals PC.
- im_rdata  in  DATA_W  IM read data, asynchronous, valid in the same cycle.
- dm_addr  out  DATA_W  equals AR.
- dm_rdata  in  DATA_W  DM read data, asynchronous.
- dm_wdata  out  DATA_W  equals bus.
- dm_we  out  1  equals write_en[11].
- bus_err  out  1  sticky illegal-source flag.

Behaviour:
- Reset: on posedge with rst=1, all registers, zero flag and bus_err go to 0. Outputs follow: instruction=0, z=0, im_addr=0, dm_addr=0. Reset overrides every strobe, including mid-instruction.
- Bus source by read_en (combinational):
  - 0: zero.
  - 1: PC.
  - 2: AR.
  - 4: IR>>OPC_W (operand field, zero-extended).
  - 5: AC.
  - 6: R.
  - 7/8/9/10: R1/R2/R3/R4.
  - 12: dm_rdata.
  - 13: im_rdata.
  - 3, 11, 14, 15: bus=0 and bus_err set on that posedge; bus_err stays set until rst.
- Strobe bit map (write_en):
  - 1 PC, 2 AR, 3 IR, 4 AC, 5 R.
  - 7 R4, 8 R3, 9 R2, 10 R1.
  - 11 DM write, 12 ALU->AC.
  - All other bits ignored.
- inc_en: bit 1 PC, bit 4 AC; other bits ignored.
- clr_en: bit 1 PC, bit 2 AR, bit 4 AC; other bits ignored.
- Per-register priority within a cycle: clr > write_en[12] (AC only) > write_en[n] > inc. The lower-priority action is dropped.
- Increment wraps modulo 2^DATA_W (PC at all-ones goes to 0).
- Load latency: one edge. Value presented on the bus in cycle N is visible in the register after posedge N.
- ALU: combinational on AC and R; result truncated to DATA_W.
  - 1: AC+R.
  - 2: AC-R (two's complement wrap).
  - 3: low DATA_W bits of AC*R.
  - 4: AC<<1, zero fill.
  - Other codes: AC unchanged.
- ALU result is loaded into AC only when write_en[12]=1.
- Zero flag:
  - Registered; updated on every posedge that changes AC (write, ALU load, inc, clr). It is set iff the new AC value is 0.
  - Holds its value otherwise.
  - z reflects the flag, not AC combinationally.
- DM write: dm_we = write_en[11] combinationally, with dm_addr=AR and dm_wdata=bus in the same cycle. The memory commits on posedge.
- Multiple simultaneous write strobes to different registers are legal; all load the same bus value.

Optional Feature:
- Macro: DP_HALT_FREEZE_EN.
- Defined: adds input `halt` (1 bit). While halt=1:
  - all register, flag and bus_err updates are suppressed;
  - dm_we is forced to 0;
  - rst still takes effect.
- Not defined: no `halt` port; behaviour exactly as above.

Test Plan:
- Reset mid-operation: assert rst while write_en[4]=1 with bus=16'h00FF → AC=0, z=0, bus_err=0 after the edge.
- Fetch path: PC=0, im_rdata=16'h0283, read_en=13, write_en[3]=1, then inc_en[1]=1 → IR=16'h0283, instruction=6'h03, PC=1, im_addr=1.
- Arithmetic and zero flag:
  - AC=5, R=5, alu_op=2, write_en[12]=1 → AC=0, z=16'd1.
  - Then alu_op=3 with AC=3, R=16'h8001 → AC=16'h8003, z=0.
- Priority and wrap:
  - PC=16'hFFFF, inc_en[1]=1 → PC=0.
  - Same cycle clr_en[4]=1, write_en[4]=1, inc_en[4]=1 → AC=0.
- DM store and illegal source:
  - AR=16'h0010, AC=16'h1234, read_en=5, write_en[11]=1 → dm_we=1, dm_addr=16'h0010, dm_wdata=16'h1234.
  - Next cycle read_en=14 → bus=0, bus_err=1, held until rst.
- Halt (with DP_HALT_FREEZE_EN): halt=1 with write_en[4]=1 and bus=16'h0042 → AC unchanged, dm_we=0. With halt=0 the load completes.
